// File: rtl/mem_arbiter.sv
// Single-owner arbiter/sequencer in front of the byte-serial memory controller.
// Optional icache starvation guard is enabled with `define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_valid,
  input  logic [31:0] ic_addr,
  input  logic        lsb_valid,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic        lsb_r_nw,
  input  logic [2:0]  lsb_type,
  input  logic        flush_in,
  input  logic        io_buffer_full,
  output logic        mc_activate,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_data,
  output logic        mc_r_nw,
  output logic [2:0]  mc_type,
  input  logic [31:0] mc_data_in,
  input  logic        mc_done,
  output logic        ic_done,
  output logic [31:0] ic_rdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LSB} owner_t;

  state_t state, state_nxt;
  owner_t owner;
  logic   cancel;
  logic   ic_elig, lsb_elig, lsb_io_wr, force_ic;
  logic   grant_ic, grant_lsb;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign ic_elig   = ic_valid && !flush_in;
  assign lsb_io_wr = !lsb_r_nw && (lsb_addr >= IO_BASE) && (lsb_addr <= IO_BASE + 32'd7);
  assign lsb_elig  = lsb_valid && !(lsb_io_wr && io_buffer_full);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CW-1:0] starve_cnt;

  assign force_ic = (starve_cnt == CW'(STARVE_LIMIT));

  // Counts LSB wins over a waiting icache; saturates so a flushed icache can't wrap it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in) begin
      if (grant_ic || (state == IDLE && !ic_valid))
        starve_cnt <= '0;
      else if (grant_lsb && ic_valid && !force_ic)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign force_ic = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    grant_ic    = 1'b0;
    grant_lsb   = 1'b0;
    mc_activate = 1'b0;
    busy        = 1'b0;
    ic_done     = 1'b0;
    lsb_done    = 1'b0;
    case (state)
      IDLE: begin
        if (lsb_elig && !(force_ic && ic_elig)) begin
          grant_lsb = 1'b1;
          state_nxt = BUSY;
        end else if (ic_elig) begin
          grant_ic  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mc_activate = 1'b1;
        busy        = 1'b1;
        if (mc_done) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ic_done   = (owner == OWN_IC) && !cancel;
        lsb_done  = (owner == OWN_LSB);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cancel    <= 1'b0;
      mc_addr   <= '0;
      mc_data   <= '0;
      mc_r_nw   <= 1'b1;
      mc_type   <= '0;
      ic_rdata  <= '0;
      lsb_rdata <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      if (grant_lsb) begin
        owner   <= OWN_LSB;
        mc_addr <= lsb_addr;
        mc_data <= lsb_data;
        mc_r_nw <= lsb_r_nw;
        mc_type <= lsb_type;
      end else if (grant_ic) begin
        owner   <= OWN_IC;
        mc_addr <= ic_addr;
        mc_data <= '0;
        mc_r_nw <= 1'b1;
        mc_type <= 3'b000;
      end
      // A cancelled fetch still runs to completion; only its done pulse is dropped.
      if (state == BUSY) begin
        if (owner == OWN_IC && flush_in) cancel <= 1'b1;
        if (mc_done) begin
          if (owner == OWN_IC) ic_rdata  <= mc_data_in;
          else                 lsb_rdata <= mc_data_in;
        end
      end
      if (state == RESP) cancel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected controller transactions are queued
// as stimulus is applied and checked when the arbiter issues and completes them.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, ic_valid, lsb_valid, lsb_r_nw, flush_in, io_buffer_full;
  logic [31:0] ic_addr, lsb_addr, lsb_data, mc_data_in;
  logic [2:0]  lsb_type;
  logic        mc_done;
  logic        mc_activate, mc_r_nw, ic_done, lsb_done, busy;
  logic [31:0] mc_addr, mc_data, ic_rdata, lsb_rdata;
  logic [2:0]  mc_type;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_valid(ic_valid), .ic_addr(ic_addr),
    .lsb_valid(lsb_valid), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_r_nw(lsb_r_nw), .lsb_type(lsb_type),
    .flush_in(flush_in), .io_buffer_full(io_buffer_full),
    .mc_activate(mc_activate), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_r_nw(mc_r_nw), .mc_type(mc_type),
    .mc_data_in(mc_data_in), .mc_done(mc_done),
    .ic_done(ic_done), .ic_rdata(ic_rdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .busy(busy)
  );

  // flush_mode: 0 none, 1 flush two cycles before mc_done, 2 flush with mc_done
  typedef struct {
    logic        is_ic;
    logic [31:0] addr;
    logic [31:0] data;
    logic        r_nw;
    logic [2:0]  typ;
    logic [31:0] rdata;
    int          flush_mode;
    int          freeze;
    logic        keep;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic add(input logic is_ic, input logic [31:0] addr, input logic [31:0] data,
                     input logic r_nw, input logic [2:0] typ, input logic [31:0] rdata,
                     input int fm, input int fz, input logic keep);
    exp_t e;
    e.is_ic = is_ic; e.addr = addr; e.data = data; e.r_nw = r_nw; e.typ = typ;
    e.rdata = rdata; e.flush_mode = fm; e.freeze = fz; e.keep = keep;
    sb.push_back(e);
  endtask

  task automatic wait_act();
    int n = 0;
    while (mc_activate !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant", mc_activate, 1);
  endtask

  task automatic serve();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    wait_act();
    chk("busy", busy, 1);
    chk("mc_addr", mc_addr, e.addr);
    chk("mc_r_nw", mc_r_nw, e.r_nw);
    chk("mc_type", mc_type, e.typ);
    if (!e.r_nw) chk("mc_data", mc_data, e.data);
    for (int i = 0; i < e.freeze; i++) begin
      rdy_in = 1'b0; mc_done = 1'b1; mc_data_in = 32'hBAD0_BAD0;
      tick();
      chk("frz_act", mc_activate, 1);
      chk("frz_addr", mc_addr, e.addr);
      chk("frz_done", ic_done | lsb_done, 0);
    end
    rdy_in = 1'b1; mc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush_in = (e.flush_mode == 1 && i == 1);
      if (flush_in && e.is_ic) ic_valid = 1'b0;
      tick();
      chk("hold_act", mc_activate, 1);
    end
    flush_in = (e.flush_mode == 2);
    if (flush_in && e.is_ic) ic_valid = 1'b0;
    mc_done = 1'b1; mc_data_in = e.rdata;
    tick();
    mc_done = 1'b0; flush_in = 1'b0;
    chk("act_drop", mc_activate, 0);
    chk("ic_done", ic_done, e.is_ic && e.flush_mode == 0);
    chk("lsb_done", lsb_done, !e.is_ic);
    if (e.is_ic && e.flush_mode == 0) chk("ic_rdata", ic_rdata, e.rdata);
    if (!e.is_ic && e.r_nw) chk("lsb_rdata", lsb_rdata, e.rdata);
    if (!e.keep) begin
      if (e.is_ic) ic_valid = 1'b0;
      else         lsb_valid = 1'b0;
    end
    tick();
    chk("gap_act", mc_activate, 0);
    chk("gap_done", ic_done | lsb_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; ic_valid = 1'b0; ic_addr = '0;
    lsb_valid = 1'b0; lsb_addr = '0; lsb_data = '0; lsb_r_nw = 1'b1; lsb_type = '0;
    flush_in = 1'b0; io_buffer_full = 1'b0; mc_data_in = '0; mc_done = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_act", mc_activate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r_nw", mc_r_nw, 1);
    chk("rst_addr", mc_addr, 0);
    chk("rst_data", mc_data, 0);
    chk("rst_type", mc_type, 0);
    chk("rst_icr", ic_rdata, 0);
    chk("rst_lsbr", lsb_rdata, 0);
    chk("rst_done", ic_done | lsb_done, 0);

    // reset in the middle of an icache transaction
    ic_valid = 1'b1; ic_addr = 32'h100;
    tick();
    chk("mid_act", mc_activate, 1);
    chk("mid_addr", mc_addr, 32'h100);
    tick();
    rst_in = 1'b1; ic_valid = 1'b0;
    tick();
    rst_in = 1'b0;
    chk("post_rst_act", mc_activate, 0);
    chk("post_rst_busy", busy, 0);
    mc_done = 1'b1; mc_data_in = 32'hFFFF_0000;
    tick();
    mc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_done", ic_done | lsb_done, 0);
      chk("stray_busy", busy, 0);
      tick();
    end

    // simultaneous requests: LSB first, then icache
    ic_valid = 1'b1; ic_addr = 32'h200;
    lsb_valid = 1'b1; lsb_addr = 32'h1000; lsb_r_nw = 1'b1; lsb_type = 3'b000;
    add(1'b0, 32'h1000, 32'h0, 1'b1, 3'b000, 32'hDEADBEEF, 0, 0, 1'b0);
    add(1'b1, 32'h200, 32'h0, 1'b1, 3'b000, 32'h1234_5678, 0, 0, 1'b0);
    while (sb.size() > 0) serve();

    // IO store stalled by full buffer; icache goes around it
    io_buffer_full = 1'b1;
    lsb_valid = 1'b1; lsb_addr = 32'h30000; lsb_r_nw = 1'b0; lsb_type = 3'b010; lsb_data = 32'hA5;
    ic_valid = 1'b1; ic_addr = 32'h300;
    add(1'b1, 32'h300, 32'h0, 1'b1, 3'b000, 32'h3333_3333, 0, 0, 1'b0);
    serve();
    tick();
    chk("io_stall_busy", busy, 0);
    tick();
    chk("io_stall_act", mc_activate, 0);
    io_buffer_full = 1'b0;
    add(1'b0, 32'h30000, 32'hA5, 1'b0, 3'b010, 32'h0, 0, 0, 1'b0);
    serve();

    // top of IO range still stalls; one past it does not
    io_buffer_full = 1'b1;
    lsb_valid = 1'b1; lsb_addr = 32'h30007; lsb_data = 32'h77; lsb_type = 3'b000;
    tick(); tick();
    chk("io_top_stall", busy, 0);
    io_buffer_full = 1'b0;
    add(1'b0, 32'h30007, 32'h77, 1'b0, 3'b000, 32'h0, 0, 0, 1'b0);
    serve();
    io_buffer_full = 1'b1;
    lsb_valid = 1'b1; lsb_addr = 32'h30008; lsb_data = 32'h88; lsb_type = 3'b001;
    add(1'b0, 32'h30008, 32'h88, 1'b0, 3'b001, 32'h0, 0, 0, 1'b0);
    serve();
    io_buffer_full = 1'b0;

    // flushed fetch, then a fresh fetch, then flush coincident with mc_done
    ic_valid = 1'b1; ic_addr = 32'h40;
    add(1'b1, 32'h40, 32'h0, 1'b1, 3'b000, 32'h4040_4040, 1, 0, 1'b0);
    serve();
    ic_valid = 1'b1; ic_addr = 32'h80;
    add(1'b1, 32'h80, 32'h0, 1'b1, 3'b000, 32'hCAFE_F00D, 0, 0, 1'b0);
    serve();
    ic_valid = 1'b1; ic_addr = 32'h84;
    add(1'b1, 32'h84, 32'h0, 1'b1, 3'b000, 32'h8484_8484, 2, 0, 1'b0);
    serve();
    // LSB load ignores flush
    lsb_valid = 1'b1; lsb_addr = 32'h1234; lsb_r_nw = 1'b1; lsb_type = 3'b110;
    add(1'b0, 32'h1234, 32'h0, 1'b1, 3'b110, 32'h0000_00FF, 1, 0, 1'b0);
    serve();

    // rdy_in low for 5 cycles during BUSY
    lsb_valid = 1'b1; lsb_addr = 32'h2000; lsb_r_nw = 1'b1; lsb_type = 3'b101;
    add(1'b0, 32'h2000, 32'h0, 1'b1, 3'b101, 32'h0000_8001, 0, 5, 1'b0);
    serve();

    // continuous LSB traffic against a waiting icache
    ic_valid = 1'b1; ic_addr = 32'h500;
    lsb_valid = 1'b1; lsb_addr = 32'h4000; lsb_r_nw = 1'b1; lsb_type = 3'b000;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++)
      add(1'b0, 32'h4000, 32'h0, 1'b1, 3'b000, 32'h40 + k, 0, 0, 1'b1);
    add(1'b1, 32'h500, 32'h0, 1'b1, 3'b000, 32'h5005_5005, 0, 0, 1'b0);
    add(1'b0, 32'h4000, 32'h0, 1'b1, 3'b000, 32'h4F, 0, 0, 1'b0);
`else
    for (int k = 0; k < 6; k++)
      add(1'b0, 32'h4000, 32'h0, 1'b1, 3'b000, 32'h40 + k, 0, 0, k < 5);
    add(1'b1, 32'h500, 32'h0, 1'b1, 3'b000, 32'h5005_5005, 0, 0, 1'b0);
`endif
    while (sb.size() > 0) serve();

    tick();
    chk("end_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
